// File: rtl/sram_port0_ctrl.sv
`timescale 1ns/1ps
// Port-0 (RW) front end for the 1rw1r SRAM macro: request stream to registered macro pins,
// optional zero-fill after reset, and a credit-guarded read response FIFO.
//
// state    | meaning
// ST_IDLE  | one settle cycle after reset when no zero-fill is configured
// ST_CLEAR | zero-fill sweep, one full-mask write of 0 per cycle from address 0 upward
// ST_RUN   | accepting requests while response credit remains
module sram_port0_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WMASKS     = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  clear_busy,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [ADDR_WIDTH-1:0]   clr_addr_nxt;

    logic                    csb_nxt;
    logic                    web_nxt;
    logic [NUM_WMASKS-1:0]   wmask_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   din_nxt;

    logic [CNT_W-1:0]        credit;
    logic                    accept;
    logic                    rd_accept;
    logic                    rsp_pop;
    logic [1:0]              rd_pipe;
    logic                    rsp_push;

    logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic [DATA_WIDTH-1:0]   last_rdata;

    // Writes also wait for credit so that ready never depends on the request type.
    assign req_ready  = (state == ST_RUN) && (credit != '0);
    assign accept     = req_valid && req_ready;
    assign rd_accept  = accept && !req_we;
    assign clear_busy = (state == ST_CLEAR);

    assign rsp_valid  = (fifo_cnt != '0);
    assign rsp_pop    = rsp_valid && rsp_ready;
    assign rsp_push   = rd_pipe[1];
    assign rsp_rdata  = rsp_valid ? fifo_mem[rd_ptr] : last_rdata;

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        csb_nxt      = 1'b1;
        web_nxt      = sram_web0;
        wmask_nxt    = sram_wmask0;
        addr_nxt     = sram_addr0;
        din_nxt      = sram_din0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_RUN;
            end
            ST_CLEAR: begin
                csb_nxt      = 1'b0;
                web_nxt      = 1'b0;
                wmask_nxt    = '1;
                addr_nxt     = clr_addr;
                din_nxt      = '0;
                clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == '1) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    csb_nxt   = 1'b0;
                    web_nxt   = !req_we;
                    wmask_nxt = req_we ? req_wmask : '0;
                    addr_nxt  = req_addr;
                    din_nxt   = req_wdata;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_addr    <= '0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else begin
            state       <= state_nxt;
            clr_addr    <= clr_addr_nxt;
            sram_csb0   <= csb_nxt;
            sram_web0   <= web_nxt;
            sram_wmask0 <= wmask_nxt;
            sram_addr0  <= addr_nxt;
            sram_din0   <= din_nxt;
        end
    end

    // rd_pipe[0]: macro samples the read next edge; rd_pipe[1]: dout0 is valid, capture now.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pipe    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            credit     <= CNT_W'(RSP_DEPTH);
            last_rdata <= '0;
        end else begin
            rd_pipe  <= {rd_pipe[0], rd_accept};
            fifo_cnt <= fifo_cnt + CNT_W'(rsp_push) - CNT_W'(rsp_pop);
            credit   <= credit - CNT_W'(rd_accept) + CNT_W'(rsp_pop);
            if (rsp_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rsp_pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                last_rdata <= fifo_mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            fifo_mem[wr_ptr] <= sram_dout0;
        end
    end

endmodule
